// File: rtl/adder_op_sequencer.sv
// Synchronous launch/settle/capture wrapper around a combinational ripple adder.
// Optional overflow event counter enabled by defining ADDER_OVF_COUNT_EN.
module adder_op_sequencer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carryout,
  input  logic             add_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carryout,
  output logic             out_overflow,
`ifdef ADDER_OVF_COUNT_EN
  input  logic             ovf_clear,
  output logic [7:0]       ovf_count,
`endif
  output logic             busy
);

  localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d = in_a;
          add_b_d = in_b;
          cnt_d   = CW'(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - CW'(1);
        // Capture on the last settle edge so latency is exactly SETTLE_CYCLES.
        if (cnt_q == CW'(1)) begin
          sum_d   = add_sum;
          cout_d  = add_carryout;
          ovf_d   = add_overflow;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign out_sum      = sum_q;
  assign out_carryout = cout_q;
  assign out_overflow = ovf_q;

`ifdef ADDER_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clear) begin
      ovf_cnt_q <= '0;
    end else if (state_q == HOLD && out_ready && ovf_q && ovf_cnt_q != 8'hFF) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Randomized self-checking bench for adder_op_sequencer with an arithmetic reference model.
module tb_adder_op_sequencer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carryout, add_overflow;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carryout, out_overflow;
  logic             busy;
  logic [WIDTH:0]   raw_sum;
`ifdef ADDER_OVF_COUNT_EN
  logic             ovf_clear;
  logic [7:0]       ovf_count;
`endif

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned ovf_exp      = 0;

  always #5 clk = ~clk;

  // Stand-in for the ripple adder the sequencer normally drives.
  assign raw_sum      = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum      = raw_sum[WIDTH-1:0];
  assign add_carryout = raw_sum[WIDTH];
  assign add_overflow = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);

  adder_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_carryout(add_carryout), .add_overflow(add_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carryout(out_carryout), .out_overflow(out_overflow),
`ifdef ADDER_OVF_COUNT_EN
    .ovf_clear(ovf_clear), .ovf_count(ovf_count),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_carryout, 0);
    check("rst_out_ovf", out_overflow, 0);
  endtask

  // One complete transaction; poke drives a competing operand during HOLD.
  task automatic run_txn(input int a, input int b, input int unsigned hold, input bit poke);
    int sa, sb, ssum, usum, waited;
    int exp_sum, exp_cout, exp_ovf;
    usum     = a + b;
    exp_sum  = usum % 16;
    exp_cout = (usum > 15) ? 1 : 0;
    sa       = (a >= 8) ? a - 16 : a;
    sb       = (b >= 8) ? b - 16 : b;
    ssum     = sa + sb;
    exp_ovf  = (ssum > 7 || ssum < -8) ? 1 : 0;

    check("in_ready_pre", in_ready, 1);
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("launch_a", add_a, a);
    check("launch_b", add_b, b);
    check("busy_settle", busy, 1);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("latency", waited, SETTLE);
    check("out_sum", out_sum, exp_sum);
    check("out_cout", out_carryout, exp_cout);
    check("out_ovf", out_overflow, exp_ovf);

    if (poke) begin
      in_a     = 4'd2;
      in_b     = 4'd2;
      in_valid = 1'b1;
    end
    for (int h = 0; h < int'(hold); h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", out_sum, exp_sum);
      check("hold_ovf", out_overflow, exp_ovf);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_ovf != 0 && ovf_exp < 255) ovf_exp++;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_add_a", add_a, a);
    check("post_sum_kept", out_sum, exp_sum);
`ifdef ADDER_OVF_COUNT_EN
    check("ovf_count", ovf_count, ovf_exp);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
`ifdef ADDER_OVF_COUNT_EN
    ovf_clear = 1'b0;
`endif
    #2;
    check_idle_reset_values();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(3, 4, 0, 0);
    run_txn(7, 1, 1, 0);
    run_txn(15, 1, 0, 0);
    run_txn(8, 8, 2, 0);
    run_txn(9, 5, 6, 1);
    run_txn(2, 2, 0, 0);

    // Abort during the second settle cycle.
    in_a = 4'd5; in_b = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_idle_reset_values();
    ovf_exp = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < SETTLE + 2; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);

    for (int i = 0; i < 3; i++) run_txn(7, 1, 0, 0);
    run_txn(1, 1, 0, 0);
`ifdef ADDER_OVF_COUNT_EN
    check("ovf_count_3", ovf_count, 3);
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    ovf_exp   = 0;
    check("ovf_cleared", ovf_count, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(15)), int'($urandom_range(15)),
              $urandom_range(3), bit'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/adder_op_sequencer.md
Name: adder_op_sequencer

Overview:
- Clocked front-end/back-end wrapper for the team's gate-delay 4-bit ripple adder with overflow detection.
- Accepts an operand pair over a valid/ready handshake and drives the operands to the adder, holding them stable.
- Waits a programmable number of clock cycles for the ripple to settle, then captures sum, carryout and overflow into registers.
- Presents the captured result downstream over a valid/ready handshake. This gives the combinational adder a synchronous interface for the rest of the design.

Parameters:
- WIDTH, 4, operand/sum width. Must match the adder instance.
- SETTLE_CYCLES, 4, clock cycles between operand launch and result capture. Minimum 1. SETTLE_CYCLES × clock period must exceed the adder's worst-case carry-ripple plus overflow-logic delay.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A, 2's complement.
- in_b  input  WIDTH  operand B, 2's complement.
- add_a  output  WIDTH  registered operand A to the adder's a input.
- add_b  output  WIDTH  registered operand B to the adder's b input.
- add_sum  input  WIDTH  adder sum output.
- add_carryout  input  1  adder carryout.
- add_overflow  input  1  adder signed-overflow flag.
- out_valid  output  1  captured result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  captured sum.
- out_carryout  output  1  captured carryout.
- out_overflow  output  1  captured overflow.
- busy  output  1  high in SETTLE or HOLD.

Behaviour:
- Reset (async, active-high): state=IDLE, settle counter=0, add_a=add_b=0, out_sum=0, out_carryout=0, out_overflow=0, out_valid=0. in_ready=1 and busy=0 follow from IDLE.
- FSM has three states: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE). out_valid = (state==HOLD). busy = (state!=IDLE). All three are decoded from registered state only; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - On in_valid && in_ready at edge N: add_a<=in_a, add_b<=in_b, counter<=SETTLE_CYCLES, state<=SETTLE.
  - Otherwise IDLE holds.
- SETTLE:
  - Counter decrements each edge.
  - At the edge where counter==1: out_sum<=add_sum, out_carryout<=add_carryout, out_overflow<=add_overflow, state<=HOLD.
  - in_valid is ignored in this state.
- Latency: an accept at edge N gives out_valid high after edge N+SETTLE_CYCLES.
  - SETTLE_CYCLES=1 captures at edge N+1.
- HOLD:
  - out_* and out_valid remain stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready at an edge: state<=IDLE.
- Throughput: back-to-back operation is not overlapped. The next accept is possible at the first edge after the output handshake. Sustained rate is one result per SETTLE_CYCLES+2 cycles with out_ready and in_valid tied high.
- add_a/add_b persist from accept until the next accept. They are not cleared on return to IDLE, so adder inputs stay quiescent.
- out_* registers persist after handshake until the next capture. Consumers use them only while out_valid=1.
- Arithmetic: no modification of adder results.
  - Carryout is the unsigned carry.
  - Overflow is the adder's signed overflow, passed through unchanged.
- Reset mid-operation (SETTLE or HOLD): transaction is aborted, no result is emitted, and all outputs take reset values immediately.
- Counter width is sized to hold SETTLE_CYCLES. No wrap is possible because the counter is loaded only in IDLE.

Optional Feature:
- Macro: ADDER_OVF_COUNT_EN.
- When defined, the block adds:
  - Input ovf_clear (1 bit).
  - Output ovf_count (8 bits).
- ovf_count increments on every output handshake whose out_overflow=1, and saturates at 255.
- ovf_clear=1 synchronously zeroes the counter. If clear and increment coincide, clear wins.
- Reset zeroes ovf_count.
- When not defined, neither port exists and no counter logic is present.

Test Plan:
- Basic add: reset, then in_a=3, in_b=4, SETTLE_CYCLES=4 -> out_valid rises exactly 4 edges after accept; out_sum=7, carryout=0, overflow=0.
- Positive overflow: in_a=7, in_b=1 -> out_sum=4'b1000, carryout=0, overflow=1.
- Wrap and negative overflow:
  - in_a=15, in_b=1 -> out_sum=0, carryout=1, overflow=0.
  - in_a=8, in_b=8 -> out_sum=0, carryout=1, overflow=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> out_* stable, in_ready=0, a new in_valid with in_a=2 is ignored; release out_ready -> in_ready=1 next cycle, then accepting 2+2 yields out_sum=4.
- Reset mid-op: accept 5+6, assert reset during SETTLE cycle 2 -> out_valid stays 0, all outputs go to reset values at once, in_ready=1 after reset deasserts.
- With ADDER_OVF_COUNT_EN: three handshakes of 7+1 followed by one of 1+1 -> ovf_count=3; pulse ovf_clear -> ovf_count=0.
